// File: rtl/ledgame_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ledgame_pkg
//  Brief    : Shared types and constants for the LED blink sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package ledgame_pkg;

   // Default width of the blink-count request
   localparam int C_COUNT_W_DEFAULT = 4;

   // Sequencer states, explicit 2-bit encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   // Smallest width (at least 1) able to hold max_val without wrapping
   function automatic int timer_width(input int max_val);
      int w;
      w = 1;
      while ((w < 31) && ((2 ** w) <= max_val)) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module   : cycle_timer
//  Brief    : Loadable down-counter; expired flag is high while the count is 0.
//             Loading N-1 yields a phase that lasts exactly N cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module cycle_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic             o_expired
);

   logic [WIDTH-1:0] r_count;

   // Load on strobe, otherwise count down and hold at zero
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/led_blink_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : led_blink_sequencer
//  Brief    : Blinks an LED a requested number of times (ON/OFF phases),
//             then pulses done for one cycle. Abort and reset cancel silently.
//  Revision : 1.0 - initial release
// ============================================================================
module led_blink_sequencer
   import ledgame_pkg::*;
#(
   parameter int ON_CYCLES  = 12_000_000,
   parameter int OFF_CYCLES = 12_000_000,
   parameter int COUNT_W    = C_COUNT_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COUNT_W-1:0] count,
   input  logic               abort,
   output logic               led,
   output logic               busy,
   output logic               done
);

   localparam int c_max_cycles = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int c_timer_w    = timer_width(c_max_cycles);

   // Phase timer is loaded with length-1 so that it expires in the last cycle
   localparam logic [c_timer_w-1:0] c_on_load  = c_timer_w'(ON_CYCLES - 1);
   localparam logic [c_timer_w-1:0] c_off_load = c_timer_w'(OFF_CYCLES - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [COUNT_W-1:0]   r_remaining;
   logic                 w_load;
   logic [c_timer_w-1:0] w_load_val;
   logic                 w_expired;
   logic                 r_led;
   logic                 r_busy;
   logic                 r_done;
   logic                 w_led_nxt;
   logic                 w_busy_nxt;
   logic                 w_done_nxt;

   cycle_timer #(
      .WIDTH (c_timer_w)
   ) u_cycle_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_expired  (w_expired)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; abort overrides everything including start
   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (start) w_state_nxt = (count != '0) ? ST_ON : ST_FIN;
            ST_ON:   if (w_expired) w_state_nxt = ST_OFF;
            ST_OFF:  if (w_expired) w_state_nxt = (r_remaining != '0) ? ST_ON : ST_FIN;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Reload the phase timer whenever a new ON or OFF phase begins
   always_comb begin
      w_load     = (w_state_nxt != r_state) &&
                   ((w_state_nxt == ST_ON) || (w_state_nxt == ST_OFF));
      w_load_val = (w_state_nxt == ST_ON) ? c_on_load : c_off_load;
   end

   // Remaining-blinks counter: latched on acceptance, decremented leaving ON
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_remaining <= '0;
      end else if (abort) begin
         r_remaining <= '0;
      end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_ON)) begin
         r_remaining <= count;
      end else if ((r_state == ST_ON) && (w_state_nxt == ST_OFF) && (r_remaining != '0)) begin
         r_remaining <= r_remaining - COUNT_W'(1);
      end
   end

   // Output decode from the upcoming state so the registered outputs track it
   always_comb begin
      w_led_nxt  = (w_state_nxt == ST_ON);
      w_busy_nxt = (w_state_nxt == ST_ON) || (w_state_nxt == ST_OFF);
      w_done_nxt = (w_state_nxt == ST_FIN);
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_led  <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_led  <= w_led_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   assign led  = r_led;
   assign busy = r_busy;
   assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_blink_sequencer
//  Brief    : Self-checking bench; expected outputs come from an arithmetic
//             model of an accepted sequence (start cycle, blink count).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_blink_sequencer;

   localparam int P_ON  = 3;
   localparam int P_OFF = 2;
   localparam int P_PER = P_ON + P_OFF;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] count;
   logic       abort;
   logic       led;
   logic       busy;
   logic       done;

   int  t;
   int  n_checks;
   int  n_fail;
   bit  checking;
   bit  m_active;
   int  m_k;
   int  m_n;

   led_blink_sequencer #(
      .ON_CYCLES  (P_ON),
      .OFF_CYCLES (P_OFF),
      .COUNT_W    (4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .count (count),
      .abort (abort),
      .led   (led),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count a comparison and report any mismatch
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, t, obs, exp);
      end
   endtask

   // Drive one cycle, compare outputs mid-cycle, then advance the model at the edge
   task automatic step(input bit s, input int c, input bit a, input bit r);
      int d;
      int total;
      bit e_led;
      bit e_busy;
      bit e_done;
      bit idle;
      start = s;
      count = 4'(c);
      abort = a;
      rst   = r;
      @(negedge clk);
      d      = t - (m_k + 1);
      total  = m_n * P_PER;
      e_busy = m_active && (d >= 0) && (d < total);
      e_led  = e_busy && ((d % P_PER) < P_ON);
      e_done = m_active && (d == total);
      idle   = !m_active || (d > total);
      if (checking) begin
         check("led",  {31'b0, led},  {31'b0, e_led});
         check("busy", {31'b0, busy}, {31'b0, e_busy});
         check("done", {31'b0, done}, {31'b0, e_done});
         check("led_done_excl", {31'b0, led & done}, 32'd0);
      end
      if (!r) begin
         m_active = 1'b0;
         checking = 1'b1;
      end else if (a) begin
         m_active = 1'b0;
      end else if (s && idle) begin
         m_active = 1'b1;
         m_k      = t;
         m_n      = c;
      end
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 15), 1'b0, 1'b1);
   endtask

   initial begin
      bit prev_rst_low;
      bit s;
      bit a;
      bit r;
      t        = 0;
      n_checks = 0;
      n_fail   = 0;
      checking = 1'b0;
      m_active = 1'b0;
      m_k      = 0;
      m_n      = 0;
      rst      = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      count    = 4'd0;
      @(posedge clk);
      #1;

      // Reset, then observe quiet outputs
      step(1'b0, 0, 1'b0, 1'b0);
      step(1'b1, 5, 1'b0, 1'b0);
      idle_cycles(2);

      // Two blinks; stray start and count changes while busy
      step(1'b1, 2, 1'b0, 1'b1);
      idle_cycles(3);
      step(1'b1, 9, 1'b0, 1'b1);
      idle_cycles(10);

      // Zero-length request goes straight to done
      step(1'b1, 0, 1'b0, 1'b1);
      idle_cycles(3);

      // Start during busy and during FIN ignored; start right after FIN accepted
      step(1'b1, 1, 1'b0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b1, 3, 1'b0, 1'b1);
      idle_cycles(3);
      step(1'b1, 2, 1'b0, 1'b1);
      step(1'b1, 1, 1'b0, 1'b1);
      idle_cycles(8);

      // Abort mid-sequence
      step(1'b1, 3, 1'b0, 1'b1);
      idle_cycles(3);
      step(1'b0, 0, 1'b1, 1'b1);
      idle_cycles(20);

      // Reset mid-sequence, restart after release
      step(1'b1, 2, 1'b0, 1'b1);
      idle_cycles(6);
      step(1'b0, 0, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b1, 1, 1'b0, 1'b1);
      idle_cycles(8);

      // Start and abort together in IDLE
      step(1'b1, 2, 1'b1, 1'b1);
      idle_cycles(3);

      // Randomized traffic
      prev_rst_low = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         s = ($urandom_range(0, 3) == 0) && !prev_rst_low;
         a = ($urandom_range(0, 39) == 0);
         r = !($urandom_range(0, 79) == 0);
         step(s, $urandom_range(0, 5), a, r);
         prev_rst_low = !r;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
